assoc_cache: RTL

ASSOC_CACHE -- requirements
Module: assoc_cache

---
 rtl/cache_pkg.sv | 19 +
 rtl/cache_lru.sv | 73 +++++++
 rtl/assoc_cache.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/cache_pkg.sv
// Shared definitions for the set-associative read cache.
// Holds the controller state encoding and the line offset width.
package cache_pkg;

    localparam int OFFSET_BITS = 2;

    typedef enum logic [1:0] {
        IDLE,
        LOOKUP,
        REFILL,
        RESPOND
    } state_t;

    // A one-way cache still needs a 1-bit way number to keep port widths legal.
    function automatic int way_bits(input int ways);
        return (ways > 1) ? $clog2(ways) : 1;
    endfunction

endpackage

// File: rtl/cache_lru.sv
// Per-set replacement state: 1-bit LRU for two ways, tree-PLRU for four ways.
// Picks the victim as the lowest invalid way, else the least recently used way.
module cache_lru
    import cache_pkg::*;
#(
    parameter int SETS = 16,
    parameter int WAYS = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      update,
    input  logic [$clog2(SETS)-1:0]   index,
    input  logic [way_bits(WAYS)-1:0] update_way,
    input  logic [WAYS-1:0]           valid_mask,
    output logic [way_bits(WAYS)-1:0] victim_way
);

    localparam int WB = way_bits(WAYS);

    logic [WB-1:0] lru_way;

    generate
        if (WAYS == 1) begin : g_direct
            logic unused_lru;
            assign unused_lru = ^{clk, rst_n, update, index, update_way};
            assign lru_way    = '0;
        end else begin : g_plru
            logic [WAYS-2:0] tree [SETS];
            logic [WAYS-2:0] cur_tree;
            logic [WAYS-2:0] next_tree;

            assign cur_tree = tree[index];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int s = 0; s < SETS; s++) begin
                        tree[s] <= '0;
                    end
                end else if (update) begin
                    tree[index] <= next_tree;
                end
            end

            if (WAYS == 2) begin : g_two
                // The stored bit names the way that was not touched last.
                assign next_tree = ~update_way;
                assign lru_way   = cur_tree;
            end else begin : g_four
                // Bit 0 picks the colder half; bits 1 and 2 pick within each half.
                always_comb begin
                    next_tree    = cur_tree;
                    next_tree[0] = ~update_way[1];
                    if (update_way[1]) begin
                        next_tree[2] = ~update_way[0];
                    end else begin
                        next_tree[1] = ~update_way[0];
                    end
                end
                assign lru_way = cur_tree[0] ? {1'b1, cur_tree[2]} : {1'b0, cur_tree[1]};
            end
        end
    endgenerate

    always_comb begin
        victim_way = lru_way;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid_mask[w]) begin
                victim_way = WB'(w);
            end
        end
    end

endmodule

// File: rtl/assoc_cache.sv
// Set-associative read cache with one word per line, PLRU replacement and set/global flush.
// A miss stalls in REFILL until main memory strobes the line back.
module assoc_cache
    import cache_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int SETS          = 16,
    parameter int WAYS          = 2
) (
    input  logic                     iCLK,
    input  logic                     iRSTn,
    input  logic                     iReq,
    input  logic [ADDRESS_WIDTH-1:0] iAddress,
    output logic                     oReady,
    output logic                     oValid,
    output logic [DATA_WIDTH-1:0]    oData,
    output logic                     oHit,
    output logic                     oMemReq,
    output logic [ADDRESS_WIDTH-1:0] oMainMemoryAddress,
    input  logic                     iMemValid,
    input  logic [DATA_WIDTH-1:0]    iMainMemoryData,
    input  logic                     iFlush,
    input  logic [$clog2(SETS)-1:0]  iFlushIndex,
    input  logic                     iFlushAll
);

    localparam int INDEX_BITS = $clog2(SETS);
    localparam int LINE_BITS  = ADDRESS_WIDTH - OFFSET_BITS;
    localparam int TAG_BITS   = LINE_BITS - INDEX_BITS;
    localparam int WB         = way_bits(WAYS);

    state_t                state;
    state_t                next_state;
    logic [LINE_BITS-1:0]  req_line;
    logic [INDEX_BITS-1:0] req_index;
    logic [TAG_BITS-1:0]   req_tag;
    logic [WAYS-1:0]       valid_q [SETS];
    logic [WAYS-1:0]       set_valid;
    logic [WAYS-1:0]       hit_vec;
    logic [TAG_BITS-1:0]   way_tag [WAYS];
    logic [DATA_WIDTH-1:0] way_data [WAYS];
    logic [WB-1:0]         hit_way;
    logic [WB-1:0]         victim_way;
    logic [WB-1:0]         touch_way;
    logic                  lookup_hit;
    logic                  capture;
    logic                  hit_en;
    logic                  miss_en;
    logic                  fill_en;
    logic                  unused_offset;

    // Lines are one word wide, so the byte offset never reaches the arrays.
    assign unused_offset = ^iAddress[OFFSET_BITS-1:0];

    assign req_index = req_line[INDEX_BITS-1:0];
    assign req_tag   = req_line[LINE_BITS-1:INDEX_BITS];
    assign set_valid = valid_q[req_index];

    always_ff @(posedge iCLK or negedge iRSTn) begin
        if (!iRSTn) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:    if (iReq) next_state = LOOKUP;
            LOOKUP:  next_state = lookup_hit ? IDLE : REFILL;
            REFILL:  if (iMemValid) next_state = RESPOND;
            RESPOND: next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        oReady  = (state == IDLE);
        capture = (state == IDLE) && iReq;
        hit_en  = (state == LOOKUP) && lookup_hit;
        miss_en = (state == LOOKUP) && !lookup_hit;
        fill_en = (state == REFILL) && iMemValid;
    end

    // Valid bits come straight from the flops, so a same-cycle flush cannot hide a hit.
    always_comb begin
        hit_vec = '0;
        hit_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            hit_vec[w] = set_valid[w] && (way_tag[w] == req_tag);
        end
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (hit_vec[w]) begin
                hit_way = WB'(w);
            end
        end
    end

    assign lookup_hit = |hit_vec;

    generate
        for (genvar w = 0; w < WAYS; w++) begin : g_way
            logic [TAG_BITS-1:0]   tag_ram  [SETS];
            logic [DATA_WIDTH-1:0] data_ram [SETS];

            always_ff @(posedge iCLK) begin
                if (fill_en && (victim_way == WB'(w))) begin
                    tag_ram[req_index]  <= req_tag;
                    data_ram[req_index] <= iMainMemoryData;
                end
            end

            assign way_tag[w]  = tag_ram[req_index];
            assign way_data[w] = data_ram[req_index];
        end
    endgenerate

    // Flush is applied after the refill write so it wins when both hit one set.
    always_ff @(posedge iCLK or negedge iRSTn) begin
        if (!iRSTn) begin
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
            end
        end else begin
            if (fill_en) begin
                valid_q[req_index][victim_way] <= 1'b1;
            end
            if (iFlushAll) begin
                for (int s = 0; s < SETS; s++) begin
                    valid_q[s] <= '0;
                end
            end else if (iFlush) begin
                valid_q[iFlushIndex] <= '0;
            end
        end
    end

    assign touch_way = hit_en ? hit_way : victim_way;

    cache_lru #(
        .SETS (SETS),
        .WAYS (WAYS)
    ) u_lru (
        .clk        (iCLK),
        .rst_n      (iRSTn),
        .update     (hit_en | fill_en),
        .index      (req_index),
        .update_way (touch_way),
        .valid_mask (set_valid),
        .victim_way (victim_way)
    );

    // Memory request and address are loaded once on a miss and held until the refill lands.
    always_ff @(posedge iCLK or negedge iRSTn) begin
        if (!iRSTn) begin
            req_line           <= '0;
            oValid             <= 1'b0;
            oHit               <= 1'b0;
            oData              <= '0;
            oMemReq            <= 1'b0;
            oMainMemoryAddress <= '0;
        end else begin
            oValid <= hit_en | fill_en;
            if (capture) begin
                req_line <= iAddress[ADDRESS_WIDTH-1:OFFSET_BITS];
            end
            if (hit_en) begin
                oData <= way_data[hit_way];
                oHit  <= 1'b1;
            end
            if (miss_en) begin
                oMemReq            <= 1'b1;
                oMainMemoryAddress <= {req_line, {OFFSET_BITS{1'b0}}};
            end
            if (fill_en) begin
                oData   <= iMainMemoryData;
                oHit    <= 1'b0;
                oMemReq <= 1'b0;
            end
        end
    end

endmodule
